// File: rtl/io_pkg.sv
// Shared definitions for the I/O bus controller and the io_ports bank.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } io_state_e;

  localparam int   IO_ADDR_W    = 4;
  localparam int   IO_CNT_W     = 4;
  localparam logic IO_DIR_WRITE = 1'b1;
  localparam logic IO_DIR_READ  = 1'b0;

endpackage

// File: rtl/io_bus_ctrl.sv
// CPU-side master for the I/O port bank: one IN/OUT request at a time, strobe held ACC_CYCLES clocks.
// Optional IO_BUS_ERR_EN: requests to ports >= NUM_PORTS answer immediately with rsp_err and no bank access.
module io_bus_ctrl
  import io_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int ACC_CYCLES = 1,
  parameter int NUM_PORTS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [IO_ADDR_W-1:0] req_addr,
  input  logic [BITS-1:0]      req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_rdata,
  output logic                 rsp_err,
  output logic                 io_en,
  output logic                 io_r_or_w,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [BITS-1:0]      io_wdata,
  input  logic [BITS-1:0]      io_rdata
);

  if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc
    $error("io_bus_ctrl: ACC_CYCLES must be in 1..15");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_ports
    $error("io_bus_ctrl: NUM_PORTS must be in 1..16");
  end

  localparam logic [IO_CNT_W-1:0] CNT_LOAD = IO_CNT_W'(ACC_CYCLES - 1);
  localparam logic [IO_CNT_W-1:0] CNT_ONE  = IO_CNT_W'(1);

  io_state_e             state_q, state_d;
  logic [IO_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  io_en_q, io_en_d;
  logic                  io_r_or_w_q, io_r_or_w_d;
  logic [IO_ADDR_W-1:0]  io_addr_q, io_addr_d;
  logic [BITS-1:0]       io_wdata_q, io_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  bad_addr;

`ifdef IO_BUS_ERR_EN
  assign bad_addr = (32'(req_addr) >= NUM_PORTS);
`else
  assign bad_addr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    io_en_d     = io_en_q;
    io_r_or_w_d = io_r_or_w_q;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (bad_addr) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            io_r_or_w_d = req_write;
            io_addr_d   = req_addr;
            io_wdata_d  = req_wdata;
            io_en_d     = 1'b1;
            cnt_d       = CNT_LOAD;
            rsp_err_d   = 1'b0;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // The bank clears data_out on its first disabled negedge, so the read
          // value must be taken on the edge that leaves ACCESS.
          rsp_rdata_d = (io_r_or_w_q == IO_DIR_WRITE) ? '0 : io_rdata;
          io_en_d     = 1'b0;
          state_d     = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CAPTURE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      io_en_q     <= 1'b0;
      io_r_or_w_q <= IO_DIR_READ;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      io_en_q     <= io_en_d;
      io_r_or_w_q <= io_r_or_w_d;
      io_addr_q   <= io_addr_d;
      io_wdata_q  <= io_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign io_en     = io_en_q;
  assign io_r_or_w = io_r_or_w_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

endmodule
